score_lives_ctrl: RTL and testbench



---
 rtl/score_lives_ctrl.sv | 128 ++++++++++++
 tb/tb_score_lives_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/score_lives_ctrl.sv
// Score/lives sequencer for the four-digit seven-segment display of the VGA game.
// Edge-detects start/point/miss, tracks score, lives and high score, and blinks the lives digit at game over.
module score_lives_ctrl #(
  parameter int START_LIVES = 3,
  parameter int MAX_SCORE   = 99,
  parameter int BLINK_BITS  = 23
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       point,
  input  logic       miss,
  input  logic       show_hi,
  output logic [7:0] displayNumber,
  output logic [3:0] lives,
  output logic [1:0] game_state,
  output logic       game_over
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_PLAY = 2'b01,
    ST_OVER = 2'b10,
    ST_BAD  = 2'b11
  } state_t;

  // One extra bit so the MSB flips every 2^BLINK_BITS cycles.
  localparam int         BW      = BLINK_BITS + 1;
  localparam logic [6:0] MAX_S   = 7'(MAX_SCORE);
  localparam logic [3:0] START_L = 4'(START_LIVES);

  state_t          state_q, state_d;
  logic [6:0]      score_q, score_d;
  logic [6:0]      hi_q, hi_d;
  logic [3:0]      life_q, life_d;
  logic [BW-1:0]   blink_q, blink_d;
  logic            start_q, point_q, miss_q;
  logic            start_ev, point_ev, miss_ev;
  logic [7:0]      disp_d;
  logic [3:0]      lives_d;
  logic [1:0]      gs_d;
  logic            go_d;

  assign start_ev = start & ~start_q;
  assign point_ev = point & ~point_q;
  assign miss_ev  = miss  & ~miss_q;

  always_comb begin
    state_d = state_q;
    score_d = score_q;
    hi_d    = hi_q;
    life_d  = life_q;
    blink_d = '0;
    case (state_q)
      ST_IDLE: begin
        if (start_ev) begin
          state_d = ST_PLAY;
          score_d = '0;
          life_d  = START_L;
        end
      end
      ST_PLAY: begin
        if (point_ev && (score_q < MAX_S)) score_d = score_q + 7'd1;
        if (miss_ev && (life_q != 4'd0)) begin
          life_d = life_q - 4'd1;
          // Last life lost: the same-cycle point is already folded into score_d.
          if (life_q == 4'd1) begin
            state_d = ST_OVER;
            hi_d    = (score_d > hi_q) ? score_d : hi_q;
          end
        end
      end
      ST_OVER: begin
        if (start_ev) begin
          state_d = ST_PLAY;
          score_d = '0;
          life_d  = START_L;
        end else begin
          blink_d = blink_q + BW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    disp_d  = {1'b0, score_q};
    lives_d = life_q;
    gs_d    = state_q;
    go_d    = (state_q == ST_OVER);
    case (state_q)
      ST_IDLE: disp_d  = {1'b0, (show_hi ? hi_q : score_q)};
      ST_OVER: lives_d = blink_q[BW-1] ? 4'hF : 4'h0;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      score_q       <= '0;
      hi_q          <= '0;
      life_q        <= START_L;
      blink_q       <= '0;
      start_q       <= 1'b0;
      point_q       <= 1'b0;
      miss_q        <= 1'b0;
      displayNumber <= 8'd0;
      lives         <= START_L;
      game_state    <= 2'b00;
      game_over     <= 1'b0;
    end else begin
      state_q       <= state_d;
      score_q       <= score_d;
      hi_q          <= hi_d;
      life_q        <= life_d;
      blink_q       <= blink_d;
      start_q       <= start;
      point_q       <= point;
      miss_q        <= miss;
      displayNumber <= disp_d;
      lives         <= lives_d;
      game_state    <= gs_d;
      game_over     <= go_d;
    end
  end

endmodule

// File: tb/tb_score_lives_ctrl.sv
// Randomised scoreboard bench for score_lives_ctrl: a game-rule model queues the
// expected outputs for each clock edge and a monitor pops and compares them.
module tb_score_lives_ctrl;

  localparam int START_LIVES = 3;
  localparam int MAX_SCORE   = 99;
  localparam int BLINK_BITS  = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, point, miss, show_hi;
  logic [7:0] displayNumber;
  logic [3:0] lives;
  logic [1:0] game_state;
  logic       game_over;

  score_lives_ctrl #(
    .START_LIVES(START_LIVES),
    .MAX_SCORE  (MAX_SCORE),
    .BLINK_BITS (BLINK_BITS)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .point        (point),
    .miss         (miss),
    .show_hi      (show_hi),
    .displayNumber(displayNumber),
    .lives        (lives),
    .game_state   (game_state),
    .game_over    (game_over)
  );

  always #5 clk = ~clk;

  typedef struct {
    int dn;
    int lv;
    int gs;
    int go;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   txn    = 0;

  // Game model: 0 idle, 1 playing, 2 game over; over_cycles = edges spent in game over.
  int m_state, m_score, m_hi, m_lives, m_over_cycles;
  bit m_prev_start, m_prev_point, m_prev_miss;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_score = 0; m_hi = 0; m_lives = START_LIVES; m_over_cycles = 0;
    m_prev_start = 0; m_prev_point = 0; m_prev_miss = 0;
  endtask

  task automatic model_step(input bit s, input bit p, input bit m);
    bit es, ep, em;
    es = s && !m_prev_start;
    ep = p && !m_prev_point;
    em = m && !m_prev_miss;
    m_prev_start = s; m_prev_point = p; m_prev_miss = m;
    if (m_state == 0) begin
      if (es) begin m_state = 1; m_score = 0; m_lives = START_LIVES; end
    end else if (m_state == 1) begin
      if (ep) m_score = (m_score + 1 > MAX_SCORE) ? MAX_SCORE : m_score + 1;
      if (em && m_lives > 0) begin
        m_lives--;
        if (m_lives == 0) begin
          m_state = 2;
          m_over_cycles = 0;
          if (m_score > m_hi) m_hi = m_score;
        end
      end
    end else begin
      if (es) begin
        m_state = 1; m_score = 0; m_lives = START_LIVES; m_over_cycles = 0;
      end else begin
        m_over_cycles++;
      end
    end
  endtask

  // Drive one cycle of inputs; queue what the outputs must show at the coming edge.
  task automatic cycle(input bit s, input bit p, input bit m, input bit h);
    exp_t e;
    @(negedge clk);
    start = s; point = p; miss = m; show_hi = h;
    e.dn = (m_state == 0 && h) ? m_hi : m_score;
    e.lv = (m_state == 2) ? ((((m_over_cycles / (1 << BLINK_BITS)) % 2) == 1) ? 15 : 0) : m_lives;
    e.gs = m_state;
    e.go = (m_state == 2) ? 1 : 0;
    exp_q.push_back(e);
    model_step(s, p, m);
  endtask

  task automatic pulse(input bit s, input bit p, input bit m);
    cycle(s, p, m, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_displayNumber"}, 32'(displayNumber), 32'd0);
    chk({tag, "_lives"},         32'(lives),         32'(START_LIVES));
    chk({tag, "_game_state"},    32'(game_state),    32'd0);
    chk({tag, "_game_over"},     32'(game_over),     32'd0);
  endtask

  // Reset lands between clock edges; outputs must drop without a clock.
  task automatic do_reset();
    @(posedge clk);
    #3;
    start = 0; point = 0; miss = 0; show_hi = 0;
    rst_n = 1'b0;
    #1;
    check_reset_values("async_rst");
    model_reset();
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        txn++;
        $display("txn %0d: dn=%0d lives=%0d state=%0d over=%0d (expect dn=%0d lives=%0d state=%0d over=%0d)",
                 txn, displayNumber, lives, game_state, game_over, e.dn, e.lv, e.gs, e.go);
        chk("displayNumber", 32'(displayNumber), 32'(e.dn));
        chk("lives",         32'(lives),         32'(e.lv));
        chk("game_state",    32'(game_state),    32'(e.gs));
        chk("game_over",     32'(game_over),     32'(e.go));
      end
    end
  end

  initial begin : driver
    start = 0; point = 0; miss = 0; show_hi = 0;
    rst_n = 1'b1;
    model_reset();
    #2 rst_n = 1'b0;
    #1 check_reset_values("por");
    @(posedge clk);
    #3 rst_n = 1'b1;

    // Idle with high score shown, then first game ending at 8 with a same-cycle point+miss.
    cycle(0, 0, 0, 1); cycle(0, 0, 0, 1);
    pulse(1, 0, 0);
    repeat (5) pulse(0, 1, 0);
    repeat (10) cycle(0, 1, 0, 0);
    cycle(0, 0, 0, 0);
    pulse(0, 1, 0);
    repeat (2) pulse(0, 0, 1);
    pulse(0, 1, 1);
    repeat (24) cycle(0, 1'($urandom % 2), 1'($urandom % 2), 1'($urandom % 2));
    cycle(0, 0, 0, 0);

    // Second game ends at 3; high score must stay 8.
    pulse(1, 0, 0);
    repeat (3) pulse(0, 1, 0);
    repeat (3) pulse(0, 0, 1);
    repeat (4) cycle(0, 0, 0, 0);

    // Third game saturates at MAX_SCORE.
    pulse(1, 0, 0);
    repeat (101) pulse(0, 1, 0);
    repeat (3) pulse(0, 0, 1);
    repeat (20) cycle(0, 0, 0, 0);

    // Mid-game reset clears the high score too.
    pulse(1, 0, 0);
    repeat (4) pulse(0, 1, 0);
    do_reset();
    repeat (3) cycle(0, 0, 0, 1);

    // Random play with occasional resets.
    repeat (3000) begin
      if ($urandom % 600 == 0) do_reset();
      cycle(1'($urandom % 40 == 0), 1'($urandom % 2), 1'($urandom % 6 == 0), 1'($urandom % 2));
    end

    repeat (5) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      errors++;
      checks++;
      $display("FAIL drain: %0d expected entries never compared, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
